exec_unit: RTL and testbench

Parametrised successor to the single-cycle decode/add datapath of the prototype processor. Accepts one 8-bit instruction plus two DATASIZE-bit operands per handshake, decodes the 3-bit opcode, and executes add/sub/logic/load-immediate/LED-out in fixed latency or multiply in multi-cycle. Registers the result toward the register file and the LED port, with zero/carry flags. Sits between instruction fetch/register read and register writeback.

---
 rtl/exec_pkg.sv | 14 +
 rtl/exec_mul.sv | 52 +++++
 rtl/exec_unit.sv | 160 ++++++++++++++++
 tb/tb_exec_unit.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/exec_pkg.sv
// Shared opcode/state encodings and instruction field positions for exec_unit.
package exec_pkg;
    localparam int OPC_MSB = 7;
    localparam int OPC_LSB = 5;
    localparam int IMM_W   = 5;

    typedef enum logic [2:0] {
        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_MUL, OP_LDI, OP_OUT
    } opcode_t;

    typedef enum logic [1:0] {
        ST_IDLE, ST_DECODE, ST_EXEC, ST_MUL
    } state_t;
endpackage

// File: rtl/exec_mul.sv
// Shift-add multiplier: one partial product per enabled cycle, DATASIZE steps after start.
// done is raised once the step count is exhausted; the owner qualifies it with busy.
module exec_mul #(
    parameter int DATASIZE = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    start,
    input  logic [DATASIZE-1:0]     a,
    input  logic [DATASIZE-1:0]     b,
    output logic                    busy,
    output logic                    done,
    output logic [2*DATASIZE-1:0]   product
);
    localparam int CW = $clog2(DATASIZE + 1);

    logic [2*DATASIZE-1:0] acc;
    logic [2*DATASIZE-1:0] mcand;
    logic [DATASIZE-1:0]   mplier;
    logic [CW-1:0]         cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
            busy   <= 1'b0;
        end else if (en) begin
            if (start) begin
                acc    <= '0;
                mcand  <= (2*DATASIZE)'(a);
                mplier <= b;
                cnt    <= '0;
                busy   <= 1'b1;
            end else if (busy) begin
                if (cnt == CW'(DATASIZE)) begin
                    busy <= 1'b0;
                end else begin
                    if (mplier[0]) acc <= acc + mcand;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + CW'(1);
                end
            end
        end
    end

    assign done    = (cnt == CW'(DATASIZE));
    assign product = acc;
endmodule

// File: rtl/exec_unit.sv
// Decode/execute stage: non-MUL ops retire 2 cycles after accept, MUL (EXEC_MUL_EN) after DATASIZE+2.
// One instruction in flight; in_ready only in IDLE with main_enable, which freezes everything when low.
module exec_unit
    import exec_pkg::*;
#(
    parameter int DATASIZE = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [7:0]          instr,
    input  logic [DATASIZE-1:0] regA,
    input  logic [DATASIZE-1:0] regB,
    input  logic                main_enable,
    input  logic                in_valid,
    output logic                in_ready,
    output logic [DATASIZE-1:0] to_reg,
    output logic                out_wr,
    output logic [DATASIZE-1:0] to_leds,
    output logic                out_valid,
    output logic                flag_z,
    output logic                flag_c,
    output logic                err
);
`ifdef EXEC_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    state_t                state, state_nxt;
    logic [7:0]            instr_q;
    logic [DATASIZE-1:0]   a_q, b_q;
    opcode_t               op;
    logic                  accept, retire;
    logic                  mul_busy, mul_done;
    logic [2*DATASIZE-1:0] mul_prod;
    logic [DATASIZE:0]     sum, diff;
    logic [DATASIZE-1:0]   res;
    logic                  c_new, upd, wr, leds_ld, illegal;

    assign op       = opcode_t'(instr_q[OPC_MSB:OPC_LSB]);
    assign in_ready = (state == ST_IDLE) && main_enable;
    assign accept   = in_valid && in_ready;

`ifdef EXEC_MUL_EN
    logic mul_start;
    assign mul_start = main_enable && (state == ST_DECODE) && (op == OP_MUL);

    exec_mul #(.DATASIZE(DATASIZE)) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (main_enable),
        .start   (mul_start),
        .a       (a_q),
        .b       (b_q),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_prod)
    );
`else
    assign mul_busy = 1'b0;
    assign mul_done = 1'b0;
    assign mul_prod = '0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        retire    = 1'b0;
        if (main_enable) begin
            case (state)
                ST_IDLE:   if (in_valid) state_nxt = ST_DECODE;
                ST_DECODE: state_nxt = (MUL_EN && op == OP_MUL) ? ST_MUL : ST_EXEC;
                ST_EXEC: begin
                    retire    = 1'b1;
                    state_nxt = ST_IDLE;
                end
                ST_MUL: if (mul_busy && mul_done) begin
                    retire    = 1'b1;
                    state_nxt = ST_IDLE;
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    assign sum  = {1'b0, a_q} + {1'b0, b_q};
    assign diff = {1'b0, a_q} - {1'b0, b_q};

    always_comb begin
        res     = '0;
        c_new   = 1'b0;
        upd     = 1'b0;
        wr      = 1'b0;
        leds_ld = 1'b0;
        illegal = 1'b0;
        case (op)
            OP_ADD: begin res = sum[DATASIZE-1:0];  c_new = sum[DATASIZE];  upd = 1'b1; wr = 1'b1; end
            OP_SUB: begin res = diff[DATASIZE-1:0]; c_new = diff[DATASIZE]; upd = 1'b1; wr = 1'b1; end
            OP_AND: begin res = a_q & b_q; upd = 1'b1; wr = 1'b1; end
            OP_OR:  begin res = a_q | b_q; upd = 1'b1; wr = 1'b1; end
            OP_XOR: begin res = a_q ^ b_q; upd = 1'b1; wr = 1'b1; end
            OP_MUL: begin
                if (MUL_EN) begin
                    res   = mul_prod[DATASIZE-1:0];
                    c_new = |mul_prod[2*DATASIZE-1:DATASIZE];
                    upd   = 1'b1;
                    wr    = 1'b1;
                end else begin
                    illegal = 1'b1;
                end
            end
            OP_LDI: begin res = DATASIZE'(instr_q[IMM_W-1:0]); wr = 1'b1; end
            OP_OUT: leds_ld = 1'b1;
            default: illegal = 1'b1;
        endcase
    end

    // Pulses clear on every edge, frozen or not, so they never stretch.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            instr_q   <= '0;
            a_q       <= '0;
            b_q       <= '0;
            to_reg    <= '0;
            to_leds   <= '0;
            flag_z    <= 1'b0;
            flag_c    <= 1'b0;
            out_valid <= 1'b0;
            out_wr    <= 1'b0;
            err       <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            out_wr    <= 1'b0;
            err       <= 1'b0;
            if (accept) begin
                instr_q <= instr;
                a_q     <= regA;
                b_q     <= regB;
            end
            if (retire) begin
                out_valid <= 1'b1;
                err       <= illegal;
                if (wr) begin
                    to_reg <= res;
                    out_wr <= 1'b1;
                end
                if (upd) begin
                    flag_z <= (res == '0);
                    flag_c <= c_new;
                end
                if (leds_ld) to_leds <= a_q;
            end
        end
    end
endmodule

// File: tb/tb_exec_unit.sv
// Directed bench for exec_unit: a reference model pushes expectations, retirements pop and compare.
module tb_exec_unit;
    localparam int W = 8;
`ifdef EXEC_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    typedef struct {
        logic [W-1:0] reg_v;
        logic [W-1:0] leds;
        logic         z;
        logic         c;
        logic         wr;
        logic         err;
        int           lat;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [7:0]   instr;
    logic [W-1:0] regA, regB;
    logic         main_enable, in_valid;
    logic         in_ready, out_wr, out_valid, flag_z, flag_c, err;
    logic [W-1:0] to_reg, to_leds;

    int tests = 0;
    int fails = 0;

    exp_t sb[$];
    logic [W-1:0] m_reg, m_leds;
    logic         m_z, m_c;

    exec_unit #(.DATASIZE(W)) dut (
        .clk(clk), .rst_n(rst_n), .instr(instr), .regA(regA), .regB(regB),
        .main_enable(main_enable), .in_valid(in_valid), .in_ready(in_ready),
        .to_reg(to_reg), .out_wr(out_wr), .to_leds(to_leds), .out_valid(out_valid),
        .flag_z(flag_z), .flag_c(flag_c), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [7:0] ins, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t         e;
        logic [W:0]   s;
        logic [2*W-1:0] p;
        logic [W-1:0] r;
        logic         nc, upd, wr;
        r = '0; nc = 1'b0; upd = 1'b0; wr = 1'b0;
        e.err = 1'b0;
        e.lat = 2;
        case (ins[7:5])
            3'd0: begin s = {1'b0, a} + {1'b0, b}; r = s[W-1:0]; nc = s[W]; upd = 1; wr = 1; end
            3'd1: begin r = a - b; nc = (a < b); upd = 1; wr = 1; end
            3'd2: begin r = a & b; upd = 1; wr = 1; end
            3'd3: begin r = a | b; upd = 1; wr = 1; end
            3'd4: begin r = a ^ b; upd = 1; wr = 1; end
            3'd5: begin
                if (MUL_EN) begin
                    p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
                    r = p[W-1:0]; nc = |p[2*W-1:W]; upd = 1; wr = 1;
                    e.lat = W + 2;
                end else begin
                    e.err = 1'b1;
                end
            end
            3'd6: begin r = W'(ins[4:0]); wr = 1; end
            default: m_leds = a;
        endcase
        if (upd) begin m_z = (r == '0); m_c = nc; end
        if (wr) m_reg = r;
        e.reg_v = m_reg; e.leds = m_leds; e.z = m_z; e.c = m_c; e.wr = wr;
        return e;
    endfunction

    // Issue one instruction, optionally freezing main_enable for fz_len cycles starting fz_at cycles after accept.
    task automatic run_op(input string tag, input logic [7:0] ins, input logic [W-1:0] a,
                          input logic [W-1:0] b, input int fz_at, input int fz_len);
        exp_t e, ev;
        int   k;
        bit   seen, ir_bad;
        e = model(ins, a, b);
        if (fz_len > 0 && fz_at < e.lat) e.lat += fz_len;
        sb.push_back(e);
        @(negedge clk);
        instr = ins; regA = a; regB = b; in_valid = 1'b1;
        check({tag, ".in_ready_idle"}, 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        k = 0; seen = 1'b0; ir_bad = 1'b0;
        while (!seen && k < 200) begin
            if (fz_len > 0 && k == fz_at) main_enable = 1'b0;
            if (fz_len > 0 && k == fz_at + fz_len) main_enable = 1'b1;
            @(posedge clk); #1;
            k++;
            if (out_valid) seen = 1'b1;
            else if (in_ready) ir_bad = 1'b1;
        end
        main_enable = 1'b1;
        check({tag, ".retired"}, 32'(seen), 32'd1);
        ev = sb.pop_front();
        if (seen) begin
            check({tag, ".latency"}, 32'(k), 32'(ev.lat));
            check({tag, ".to_reg"},  32'(to_reg), 32'(ev.reg_v));
            check({tag, ".to_leds"}, 32'(to_leds), 32'(ev.leds));
            check({tag, ".flag_z"},  32'(flag_z), 32'(ev.z));
            check({tag, ".flag_c"},  32'(flag_c), 32'(ev.c));
            check({tag, ".out_wr"},  32'(out_wr), 32'(ev.wr));
            check({tag, ".err"},     32'(err), 32'(ev.err));
            check({tag, ".busy_no_ready"}, 32'(ir_bad), 32'd0);
            @(posedge clk); #1;
            check({tag, ".pulse_1cyc"}, 32'(out_valid), 32'd0);
        end
    endtask

    initial begin
        bit saw_valid;
        rst_n = 1'b0; main_enable = 1'b1; in_valid = 1'b0;
        instr = '0; regA = '0; regB = '0;
        m_reg = '0; m_leds = '0; m_z = 1'b0; m_c = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst.to_reg", 32'(to_reg), 32'd0);
        check("rst.to_leds", 32'(to_leds), 32'd0);
        check("rst.flags", {30'd0, flag_z, flag_c}, 32'd0);
        check("rst.pulses", {29'd0, out_valid, out_wr, err}, 32'd0);
        check("rst.in_ready", 32'(in_ready), 32'd1);
        rst_n = 1'b1;

        run_op("add_carry", 8'b000_00000, 8'd200, 8'd100, 0, 0);
        run_op("sub_zero",  8'b001_00000, 8'd5,   8'd5,   0, 0);
        run_op("sub_borrow",8'b001_00000, 8'd3,   8'd5,   0, 0);
        run_op("ldi",       8'b110_10110, 8'h77,  8'h11,  0, 0);
        run_op("out",       8'b111_00000, 8'hA5,  8'h3C,  0, 0);
        run_op("and",       8'b010_00000, 8'hF0,  8'h3C,  0, 0);
        run_op("or",        8'b011_00000, 8'hF0,  8'h0C,  0, 0);
        run_op("xor",       8'b100_00000, 8'hFF,  8'hFF,  0, 0);
        run_op("mul_15x17", 8'b101_00000, 8'd15,  8'd17,  0, 0);
        run_op("mul_16x16", 8'b101_00000, 8'd16,  8'd16,  0, 0);
        run_op("add_freeze",8'b000_00000, 8'd1,   8'd2,   1, 3);
        if (MUL_EN) run_op("mul_freeze", 8'b101_00000, 8'd15, 8'd17, 4, 3);
        else        run_op("op5_freeze", 8'b101_00000, 8'd15, 8'd17, 1, 3);
        run_op("ldi_pre_rst", 8'b110_01001, 8'h00, 8'h00, 0, 0);

        // Abort a long-running instruction with reset.
        @(negedge clk);
        instr = MUL_EN ? 8'b101_00000 : 8'b000_00000;
        regA = 8'd13; regB = 8'd11; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (MUL_EN ? 4 : 1) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("abort.to_reg", 32'(to_reg), 32'd0);
        check("abort.to_leds", 32'(to_leds), 32'd0);
        check("abort.flags", {30'd0, flag_z, flag_c}, 32'd0);
        check("abort.pulses", {29'd0, out_valid, out_wr, err}, 32'd0);
        check("abort.in_ready", 32'(in_ready), 32'd1);
        rst_n = 1'b1;
        m_reg = '0; m_leds = '0; m_z = 1'b0; m_c = 1'b0;
        saw_valid = 1'b0;
        repeat (15) begin
            @(posedge clk); #1;
            if (out_valid) saw_valid = 1'b1;
        end
        check("abort.no_retire", 32'(saw_valid), 32'd0);

        run_op("post_rst_sub", 8'b001_00000, 8'd9, 8'd4, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
